// File: rtl/mic_frame_packer.sv
// mic_frame_packer
// Collects a TDM stream of signed per-channel ADC words into a parallel
// N_CH-element vector for the sum-of-squares energy stage. A completed frame
// appears on o_data with a one-cycle o_valid pulse in the cycle after its
// last word. There is no backpressure.
//
// Ports:
//   i_50M_clk     system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_word_valid  qualifies i_word / i_sof
//   i_sof         word is channel 0 of a new frame
//   i_word        signed IN_W sample
//   i_ch_mask     per-channel zero mask (only with MIC_FRAME_CH_MASK_EN)
//   o_valid       one-cycle pulse, o_data holds a new complete frame
//   o_data        N_CH x OUT_W sign-extended samples, element k = channel k
//   o_err_sync    one-cycle pulse on a framing error
//   o_frame_cnt   emitted-frame counter, wraps
//
// Optional feature: define MIC_FRAME_CH_MASK_EN to add i_ch_mask. It is
// sampled at the completion edge and forces masked elements to zero.
module mic_frame_packer #(
  parameter int unsigned N_CH  = 12,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         i_50M_clk,
  input  logic                         i_rst,
  input  logic                         i_word_valid,
  input  logic                         i_sof,
  input  logic signed [IN_W-1:0]       i_word,
`ifdef MIC_FRAME_CH_MASK_EN
  input  logic [N_CH-1:0]              i_ch_mask,
`endif
  output logic                         o_valid,
  output logic [N_CH-1:0][OUT_W-1:0]   o_data,
  output logic                         o_err_sync,
  output logic [CNT_W-1:0]             o_frame_cnt
);

  localparam int unsigned CH_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_SOF
  } state_t;

  state_t                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  // The last channel never lands in the buffer; it goes straight to o_data.
  logic [N_CH-2:0][OUT_W-1:0]    buf_q, buf_d;
  logic [N_CH-1:0][OUT_W-1:0]    data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [OUT_W-1:0]              word_ext;

  // i_word is signed, so the size cast sign-extends.
  assign word_ext = OUT_W'(i_word);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (i_word_valid) begin
      if (i_sof) begin
        // SOF restarts a frame from any state; mid-frame it also flags an error.
        if (state_q == S_COLLECT) err_d = 1'b1;
        buf_d[0] = word_ext;
        ch_d     = CH_W'(1);
        state_d  = S_COLLECT;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // Dropped silently until the first SOF.
          end
          S_COLLECT: begin
            if (ch_q == CH_W'(N_CH - 1)) begin
              for (int unsigned k = 0; k < N_CH - 1; k++) data_d[k] = buf_q[k];
              data_d[N_CH-1] = word_ext;
`ifdef MIC_FRAME_CH_MASK_EN
              for (int unsigned k = 0; k < N_CH; k++) begin
                if (i_ch_mask[k]) data_d[k] = '0;
              end
`endif
              valid_d = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              ch_d    = '0;
              state_d = S_WAIT_SOF;
            end else begin
              buf_d[ch_q] = word_ext;
              ch_d        = ch_q + CH_W'(1);
            end
          end
          S_WAIT_SOF: begin
            err_d = 1'b1;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_50M_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_err_sync  = err_q;
  assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_mic_frame_packer.sv
module tb_mic_frame_packer;

  localparam int N = 12;

  typedef logic [N-1:0][23:0] dv_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic        sof;
    logic [15:0] w;
    logic        ev;
    logic        ee;
    logic [15:0] cnt;
    dv_t         d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wv;
  logic        sof;
  logic [15:0] word;
  logic        valid;
  logic        err;
  dv_t         data;
  logic [15:0] cnt;
`ifdef MIC_FRAME_CH_MASK_EN
  logic [N-1:0] mask;
`endif

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mic_frame_packer #(
    .N_CH (12),
    .IN_W (16),
    .OUT_W(24),
    .CNT_W(16)
  ) dut (
    .i_50M_clk   (clk),
    .i_rst       (rst),
    .i_word_valid(wv),
    .i_sof       (sof),
    .i_word      (word),
`ifdef MIC_FRAME_CH_MASK_EN
    .i_ch_mask   (mask),
`endif
    .o_valid     (valid),
    .o_data      (data),
    .o_err_sync  (err),
    .o_frame_cnt (cnt)
  );

  function automatic dv_t all_of(input logic [23:0] x);
    dv_t r;
    for (int k = 0; k < N; k++) r[k] = x;
    return r;
  endfunction

  task automatic push(input logic r, input logic v, input logic s, input logic [15:0] w,
                      input logic ev, input logic ee, input logic [15:0] c, input dv_t d);
    vec_t t;
    t.rst = r; t.v = v; t.sof = s; t.w = w;
    t.ev = ev; t.ee = ee; t.cnt = c; t.d = d;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [N*24-1:0] act,
                     input logic [N*24-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [15:0] w);
    rst = r; wv = v; sof = s; word = w;
    @(negedge clk);
  endtask

  initial begin
    dv_t z, seqd, g3;
    int pulses, first_at, second_at;
    logic saw_bad;

    rst = 1'b1; wv = 1'b0; sof = 1'b0; word = '0;
`ifdef MIC_FRAME_CH_MASK_EN
    mask = '0;
`endif
    z = '0;
    for (int k = 0; k < N; k++) seqd[k] = 24'(k + 1);
    for (int k = 0; k < N; k++) g3[k] = 24'h000100 + 24'(k);

    // Test 1: words 1..12, first with SOF.
    push(1, 0, 0, 0, 0, 0, 0, z);
    for (int i = 0; i < N; i++)
      push(0, 1, i == 0, 16'(i + 1), i == N - 1, 0, (i == N - 1) ? 16'd1 : 16'd0,
           (i == N - 1) ? seqd : z);
    push(0, 0, 0, 0, 0, 0, 1, seqd);

    // Test 2: back-to-back 7FFF frame then 8000 frame.
    push(1, 0, 0, 0, 0, 0, 0, z);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++)
        push(0, 1, i == 0, f ? 16'h8000 : 16'h7FFF, i == N - 1, 0,
             16'(f + ((i == N - 1) ? 1 : 0)),
             (i == N - 1) ? all_of(f ? 24'hFF8000 : 24'h007FFF)
                          : (f ? all_of(24'h007FFF) : z));
    push(0, 0, 0, 0, 0, 0, 2, all_of(24'hFF8000));

    // Test 3: 3-cycle gap between channels 5 and 6.
    push(1, 0, 0, 0, 0, 0, 0, z);
    for (int i = 0; i < N; i++) begin
      if (i == 6) for (int g = 0; g < 3; g++) push(0, 0, 0, 16'hDEAD, 0, 0, 0, z);
      push(0, 1, i == 0, 16'h0100 + 16'(i), i == N - 1, 0, (i == N - 1) ? 16'd1 : 16'd0,
           (i == N - 1) ? g3 : z);
    end

    // Test 4: SOF after 7 words, then a full frame of 3.
    push(1, 0, 0, 0, 0, 0, 0, z);
    for (int i = 0; i < 7; i++) push(0, 1, i == 0, 16'd50, 0, 0, 0, z);
    for (int i = 0; i < N; i++)
      push(0, 1, i == 0, 16'd3, i == N - 1, i == 0, (i == N - 1) ? 16'd1 : 16'd0,
           (i == N - 1) ? all_of(24'd3) : z);
    push(0, 0, 0, 0, 0, 0, 1, all_of(24'd3));

    // Test 5: completed frame, 2 stray words, then a frame of 5.
    push(1, 0, 0, 0, 0, 0, 0, z);
    for (int i = 0; i < N; i++)
      push(0, 1, i == 0, 16'(i + 1), i == N - 1, 0, (i == N - 1) ? 16'd1 : 16'd0,
           (i == N - 1) ? seqd : z);
    push(0, 1, 0, 16'd99, 0, 1, 1, seqd);
    push(0, 1, 0, 16'd99, 0, 1, 1, seqd);
    for (int i = 0; i < N; i++)
      push(0, 1, i == 0, 16'd5, i == N - 1, 0, (i == N - 1) ? 16'd2 : 16'd1,
           (i == N - 1) ? all_of(24'd5) : seqd);

    // Test 6: reset after 6 words, IDLE drops, then a frame of -2.
    push(1, 0, 0, 0, 0, 0, 0, z);
    for (int i = 0; i < N; i++)
      push(0, 1, i == 0, 16'(i + 1), i == N - 1, 0, (i == N - 1) ? 16'd1 : 16'd0,
           (i == N - 1) ? seqd : z);
    for (int i = 0; i < 6; i++) push(0, 1, i == 0, 16'd77, 0, 0, 1, seqd);
    push(1, 0, 0, 0, 0, 0, 0, z);
    push(0, 1, 0, 16'd44, 0, 0, 0, z);
    push(0, 1, 0, 16'd45, 0, 0, 0, z);
    for (int i = 0; i < N; i++)
      push(0, 1, i == 0, 16'hFFFE, i == N - 1, 0, (i == N - 1) ? 16'd1 : 16'd0,
           (i == N - 1) ? all_of(24'hFFFFFE) : z);
    push(0, 0, 0, 0, 0, 0, 1, all_of(24'hFFFFFE));
    push(0, 0, 0, 0, 0, 0, 1, all_of(24'hFFFFFE));

    // Each record's expectations apply right after the edge that samples it.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].sof, tbl[i].w);
      chk("o_valid", i, valid, tbl[i].ev);
      chk("o_err_sync", i, err, tbl[i].ee);
      chk("o_frame_cnt", i, cnt, tbl[i].cnt);
      chk("o_data", i, data, tbl[i].d);
    end

    // Pulse spacing for two gapless frames.
    drive(1, 0, 0, 0);
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i < 2 * N + 4; i++) begin
      if (i < 2 * N) drive(0, 1, (i % N) == 0, 16'(i));
      else drive(0, 0, 0, 0);
      if (valid) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
    end
    chk("pulse_count", 0, pulses, 2);
    chk("first_pulse_cycle", 0, first_at, N - 1);
    chk("pulse_spacing", 0, second_at - first_at, N);

    // Reset held while SOF words arrive, then non-SOF words in IDLE.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 16'h1234);
      chk("rst_valid", i, valid, 0);
      chk("rst_err", i, err, 0);
      chk("rst_cnt", i, cnt, 0);
      chk("rst_data", i, data, z);
    end
    saw_bad = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      drive(0, 1, 0, 16'(i + 1));
      if (valid || err) saw_bad = 1'b1;
    end
    chk("idle_drop_quiet", 0, saw_bad, 0);
    chk("idle_drop_cnt", 0, cnt, 0);

`ifdef MIC_FRAME_CH_MASK_EN
    drive(1, 0, 0, 0);
    mask = 12'h001;
    for (int i = 0; i < N; i++) drive(0, 1, i == 0, 16'd9);
    mask = '0;
    begin
      dv_t em;
      em = all_of(24'd9);
      em[0] = '0;
      chk("mask_valid", 0, valid, 1);
      chk("mask_cnt", 0, cnt, 1);
      chk("mask_data", 0, data, em);
    end
    drive(0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
